// File: rtl/tone_voice_bank_pkg.sv
// Shared types, limits and the 16-bit saturation helper for tone_voice_bank.
package tone_voice_bank_pkg;

  typedef enum logic [1:0] {
    ENV_OFF     = 2'd0,
    ENV_ATTACK  = 2'd1,
    ENV_SUSTAIN = 2'd2,
    ENV_RELEASE = 2'd3
  } env_state_t;

  typedef enum logic [1:0] {
    FR_IDLE  = 2'd0,
    FR_ACCUM = 2'd1,
    FR_OUT   = 2'd2
  } frame_state_t;

  localparam int unsigned ENV_MAX = 255;
  localparam int          PCM_MAX = 32767;
  localparam int          PCM_MIN = -32768;

  function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
    if (x > PCM_MAX) return 16'(PCM_MAX);
    if (x < PCM_MIN) return 16'(PCM_MIN);
    return 16'(x);
  endfunction

endpackage

// File: rtl/tone_voice_shaper.sv
// Per-voice waveform shaper: square always, triangle when
// TONE_VOICE_BANK_TRIANGLE_EN is defined (selected by wave_sel_i).
module tone_voice_shaper
  import tone_voice_bank_pkg::*;
(
  input  logic [8:0]         ph_i,
  input  logic [7:0]         env_i,
  input  logic               wave_sel_i,
  output logic signed [15:0] sample_c
);

  logic signed [15:0] sq_c;
  assign sq_c = ph_i[8] ? -$signed({1'b0, env_i, 7'b0}) : $signed({1'b0, env_i, 7'b0});

`ifdef TONE_VOICE_BANK_TRIANGLE_EN
  logic [7:0]         f_c;
  logic signed [8:0]  fc_c;
  logic signed [17:0] prod_c;

  // Fold the lower phase byte into a rising/falling ramp centred on zero.
  assign f_c      = ph_i[8] ? ~ph_i[7:0] : ph_i[7:0];
  assign fc_c     = $signed({1'b0, f_c}) - 9'sd128;
  assign prod_c   = fc_c * $signed({1'b0, env_i});
  assign sample_c = wave_sel_i ? 16'(prod_c) : sq_c;
`else
  logic unused_tri;
  assign unused_tri = ^{wave_sel_i, ph_i[7:0]};
  assign sample_c   = sq_c;
`endif

endmodule

// File: rtl/tone_voice_bank.sv
// Polyphonic phase-accumulator tone bank with per-voice ASR envelopes,
// time-multiplexed mix and saturating PCM output. Option: TONE_VOICE_BANK_TRIANGLE_EN.
module tone_voice_bank
  import tone_voice_bank_pkg::*;
#(
  parameter int unsigned VOICES       = 8,
  parameter int unsigned PHASE_W      = 24,
  parameter int unsigned SAMPLE_DIV   = 1042,
  parameter int unsigned ATTACK_STEP  = 8,
  parameter int unsigned RELEASE_STEP = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [VOICES-1:0]          key,
  input  logic [VOICES*PHASE_W-1:0]  pitch_inc,
  input  logic [VOICES-1:0]          wave_sel,
  input  logic                       low_batt,
  output logic signed [15:0]         pcm_out,
  output logic                       sample_stb,
  output logic [VOICES-1:0]          active
);

  localparam int unsigned DIV_W  = $clog2(SAMPLE_DIV);
  localparam int unsigned VIDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int unsigned ACC_W  = (16 + $clog2(VOICES) > 17) ? 16 + $clog2(VOICES) : 17;

  if (VOICES < 1) begin : g_err_voices
    $error("VOICES must be >= 1");
  end
  if (PHASE_W < 9) begin : g_err_phase
    $error("PHASE_W must be >= 9");
  end
  if (SAMPLE_DIV < VOICES + 2) begin : g_err_div
    $error("SAMPLE_DIV must be >= VOICES+2");
  end
  if (ATTACK_STEP < 1 || ATTACK_STEP > 255 || RELEASE_STEP < 1 || RELEASE_STEP > 255) begin : g_err_step
    $error("ATTACK_STEP/RELEASE_STEP must be 1..255");
  end

  logic [DIV_W-1:0]        div_q, div_d;
  frame_state_t            fs_q, fs_d;
  logic [VIDX_W-1:0]       vidx_q, vidx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [VOICES-1:0]       key_snap_q;
  logic                    lb_snap_q;
  logic signed [15:0]      pcm_q;
  logic                    stb_q;
  logic [VOICES-1:0]       active_q;

  logic [PHASE_W-1:0]      phase_q [VOICES];
  logic [7:0]              env_q   [VOICES];
  env_state_t              st_q    [VOICES];

  logic                    tick_c, last_c;
  logic [PHASE_W-1:0]      cur_ph, inc_c, ph_d;
  logic [7:0]              cur_env, env_up, env_dn, env_d;
  env_state_t              cur_st, st_d;
  logic                    cur_key;
  logic signed [15:0]      voice_sample_c;
  logic signed [ACC_W-1:0] acc_sum_c, mix_c;

  assign tick_c    = (div_q == DIV_W'(SAMPLE_DIV - 1));
  assign last_c    = (fs_q == FR_ACCUM) && (vidx_q == VIDX_W'(VOICES - 1));
  assign div_d     = tick_c ? '0 : div_q + DIV_W'(1);
  assign cur_ph    = phase_q[vidx_q];
  assign cur_env   = env_q[vidx_q];
  assign cur_st    = st_q[vidx_q];
  assign cur_key   = key_snap_q[vidx_q];
  assign acc_sum_c = acc_q + ACC_W'(voice_sample_c);
  assign mix_c     = lb_snap_q ? (acc_sum_c >>> 1) : acc_sum_c;

  always_comb begin
    inc_c = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (vidx_q == VIDX_W'(i)) inc_c = pitch_inc[i*PHASE_W +: PHASE_W];
    end
  end

  tone_voice_shaper u_shaper (
    .ph_i       (cur_ph[PHASE_W-1 -: 9]),
    .env_i      (cur_env),
    .wave_sel_i (wave_sel[vidx_q]),
    .sample_c   (voice_sample_c)
  );

  // Envelope/phase update for the voice in the arithmetic slot; step applies on the transition frame.
  always_comb begin
    env_up = ((9'(cur_env) + 9'(ATTACK_STEP)) >= 9'(ENV_MAX)) ? 8'(ENV_MAX) : cur_env + 8'(ATTACK_STEP);
    env_dn = (cur_env <= 8'(RELEASE_STEP)) ? 8'd0 : cur_env - 8'(RELEASE_STEP);
    st_d   = cur_st;
    env_d  = cur_env;
    ph_d   = (cur_st != ENV_OFF) ? cur_ph + inc_c : cur_ph;
    if (cur_key && cur_st != ENV_SUSTAIN) begin
      if (cur_st == ENV_OFF) ph_d = '0;
      env_d = env_up;
      st_d  = (env_up == 8'(ENV_MAX)) ? ENV_SUSTAIN : ENV_ATTACK;
    end else if (!cur_key && cur_st != ENV_OFF) begin
      env_d = env_dn;
      st_d  = (env_dn == 8'd0) ? ENV_OFF : ENV_RELEASE;
    end
  end

  // Frame sequencer: IDLE -> ACCUM (one voice per cycle) -> OUT.
  always_comb begin
    fs_d   = fs_q;
    vidx_d = vidx_q;
    acc_d  = acc_q;
    case (fs_q)
      FR_IDLE: begin
        if (tick_c) begin
          fs_d   = FR_ACCUM;
          vidx_d = '0;
          acc_d  = '0;
        end
      end
      FR_ACCUM: begin
        acc_d  = acc_sum_c;
        vidx_d = vidx_q + VIDX_W'(1);
        if (last_c) begin
          fs_d   = FR_OUT;
          vidx_d = '0;
        end
      end
      FR_OUT:  fs_d = FR_IDLE;
      default: fs_d = FR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= '0;
      fs_q       <= FR_IDLE;
      vidx_q     <= '0;
      acc_q      <= '0;
      key_snap_q <= '0;
      lb_snap_q  <= 1'b0;
      pcm_q      <= '0;
      stb_q      <= 1'b0;
    end else begin
      div_q  <= div_d;
      fs_q   <= fs_d;
      vidx_q <= vidx_d;
      acc_q  <= acc_d;
      stb_q  <= last_c;
      if (tick_c) begin
        key_snap_q <= key;
        lb_snap_q  <= low_batt;
      end
      if (last_c) pcm_q <= sat16(32'(mix_c));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < VOICES; i++) begin
        phase_q[i] <= '0;
        env_q[i]   <= '0;
        st_q[i]    <= ENV_OFF;
      end
      active_q <= '0;
    end else if (fs_q == FR_ACCUM) begin
      phase_q[vidx_q]  <= ph_d;
      env_q[vidx_q]    <= env_d;
      st_q[vidx_q]     <= st_d;
      active_q[vidx_q] <= (st_d != ENV_OFF);
    end
  end

  assign pcm_out    = pcm_q;
  assign sample_stb = stb_q;
  assign active     = active_q;

endmodule

// File: tb/tb_tone_voice_bank.sv
// Directed bench for tone_voice_bank (4 voices, 16-cycle frames, 12-bit phase).
module tb_tone_voice_bank;

  localparam int unsigned VOICES  = 4;
  localparam int unsigned PHASE_W = 12;

  logic                      clk;
  logic                      reset_n;
  logic [VOICES-1:0]         key;
  logic [VOICES*PHASE_W-1:0] pitch_inc;
  logic [VOICES-1:0]         wave_sel;
  logic                      low_batt;
  logic signed [15:0]        pcm_out;
  logic                      sample_stb;
  logic [VOICES-1:0]         active;

  int n_chk = 0;
  int n_bad = 0;

  tone_voice_bank #(
    .VOICES(VOICES), .PHASE_W(PHASE_W), .SAMPLE_DIV(16),
    .ATTACK_STEP(64), .RELEASE_STEP(255)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key(key), .pitch_inc(pitch_inc),
    .wave_sel(wave_sel), .low_batt(low_batt), .pcm_out(pcm_out),
    .sample_stb(sample_stb), .active(active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns the number of falling edges until a strobe is seen (bounded).
  task automatic wait_stb(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_stb && n < 64);
    if (!sample_stb) chk("stb_timeout", 0, 1);
  endtask

  task automatic frames(input int cnt);
    int n;
    for (int i = 0; i < cnt; i++) wait_stb(n);
  endtask

  int n;
  int seq_sq[7] = '{0, 8192, -16384, 24576, -32640, 32640, -32640};
  int seq_at[6] = '{0, 8192, 16384, 24576, 32640, 32640};
  int tri_exp;

  initial begin
    reset_n = 1'b0; key = '0; pitch_inc = '0; wave_sel = '0; low_batt = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pcm", pcm_out, 0);
    chk("rst_stb", sample_stb, 0);
    chk("rst_active", active, 0);
    reset_n = 1'b1;

    wait_stb(n);
    chk("first_stb_delay", n, 20);
    chk("idle_pcm", pcm_out, 0);
    @(negedge clk);
    chk("stb_one_cycle", sample_stb, 0);
    wait_stb(n);
    chk("stb_period", n + 1, 16);
    chk("idle_active", active, 0);

    // Single voice attack to sustain, DC output.
    key = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      wait_stb(n);
      chk($sformatf("attack_f%0d", i), pcm_out, seq_at[i]);
      if (i == 0) chk("active_rise", active, 4'b0001);
    end

    // Full-step release empties the envelope in one frame.
    key = 4'b0000;
    wait_stb(n);
    chk("release_f0", pcm_out, 32640);
    chk("release_active", active, 0);
    wait_stb(n);
    chk("release_f1", pcm_out, 0);

    // Mix saturation and low-battery halving.
    key = 4'b0011;
    frames(6);
    chk("two_sat", pcm_out, 32767);
    low_batt = 1'b1;
    wait_stb(n);
    chk("two_lowbatt", pcm_out, 32640);
    key = 4'b1111;
    wait_stb(n);
    chk("four_lowbatt_f0", pcm_out, 32640);
    frames(5);
    chk("four_lowbatt_sat", pcm_out, 32767);
    chk("four_active", active, 4'b1111);
    key = 4'b0000; low_batt = 1'b0;
    wait_stb(n);
    chk("four_rel_f0", pcm_out, 32767);
    wait_stb(n);
    chk("four_rel_f1", pcm_out, 0);
    chk("four_rel_active", active, 0);

    // Half-cycle increment flips the square sign every frame.
    pitch_inc = 48'h000_000_000_800;
    key = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      wait_stb(n);
      chk($sformatf("square_f%0d", i), pcm_out, seq_sq[i]);
    end
    key = 4'b0000;
    frames(2);

    // Waveform select on voice 0 with frozen phase.
    pitch_inc = '0; wave_sel = 4'b0001; key = 4'b0001;
    frames(5);
`ifdef TONE_VOICE_BANK_TRIANGLE_EN
    tri_exp = -32640;
`else
    tri_exp = 32640;
`endif
    chk("wave_sel_dc", pcm_out, tri_exp);

    // Reset in the middle of the accumulate phase.
    wait_stb(n);
    repeat (13) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_pcm", pcm_out, 0);
    chk("midrst_active", active, 0);
    @(negedge clk);
    chk("midrst_stb", sample_stb, 0);
    reset_n = 1'b1;
    wait_stb(n);
    chk("midrst_first_stb", n, 20);
    chk("midrst_pcm_after", pcm_out, 0);
    chk("midrst_active_after", active, 4'b0001);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
